// File: rtl/cc_receive.sv
// ============================================================================
//  Module      : cc_receive
//  Description : Serial receiver for the CC link. Recovers idle-high,
//                LSB-first, 8N1 bytes (about BIT_PERIOD clocks per bit),
//                writes each byte into a byte-wide frame buffer at
//                sequential addresses and pulses frame_rdy once SUBFRAME
//                bytes have been stored.
//
//  Parameters  : SUBFRAME    - bytes per frame (must match the transmitter)
//                BIT_PERIOD  - nominal clocks per serial bit (<= 256)
//                SYNC_STAGES - rx synchronizer depth (>= 2)
//                TIMEOUT     - idle clocks mid-frame before the partial
//                              frame is aborted (CC_RX_TIMEOUT_EN only)
//
//  Ports       : clock      in   system clock, rising edge
//                reset      in   asynchronous active-low reset
//                rx         in   serial line, asynchronous, idle high
//                wraddress  out  [11:0] buffer write address (byte index)
//                wrdata     out  [7:0]  received byte
//                wren       out  one-clock write strobe
//                frame_rdy  out  one-clock pulse after the last byte
//                frame_err  out  sticky framing-error flag
//                bytes_rcvd out  [12:0] bytes stored in the current frame
//
//  Options     : `define CC_RX_TIMEOUT_EN to abort a partial frame after
//                TIMEOUT idle clocks (clears bytes_rcvd, sets frame_err).
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_receive #(
    parameter int SUBFRAME    = 2048,
    parameter int BIT_PERIOD  = 50,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic [11:0] wraddress,
    output logic [7:0]  wrdata,
    output logic        wren,
    output logic        frame_rdy,
    output logic        frame_err,
    output logic [12:0] bytes_rcvd
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0]  c_half_bit  = 8'(BIT_PERIOD / 2 - 1);
    localparam logic [7:0]  c_full_bit  = 8'(BIT_PERIOD - 1);
    localparam logic [12:0] c_last_byte = 13'(SUBFRAME - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4,
        S_WRITE     = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    logic [7:0]             r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;

    logic [11:0]            r_wraddress;
    logic [7:0]             r_wrdata;
    logic                   r_wren;
    logic                   r_frame_rdy;
    logic                   r_frame_err;
    logic [12:0]            r_bytes_rcvd;

    logic                   w_cnt_clear;
    logic                   w_start_det;
    logic                   w_sample_bit;
    logic                   w_stop_err;
    logic                   w_write;
    logic                   w_timeout;

    // ------------------------------------------------------------------------
    // rx synchronizer; resets to the idle (high) line level so that reset
    // release never looks like a start edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cnt_clear  = 1'b0;
        w_start_det  = 1'b0;
        w_sample_bit = 1'b0;
        w_stop_err   = 1'b0;
        w_write      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_next_state = S_START;
                    w_cnt_clear  = 1'b1;
                    w_start_det  = 1'b1;
                end
            end

            // Half a bit in: a line that is high again was only a glitch.
            S_START: begin
                if (r_cnt == c_half_bit) begin
                    w_cnt_clear  = 1'b1;
                    w_next_state = w_rxs ? S_IDLE : S_DATA;
                end
            end

            // From mid-start, every full bit period lands mid-bit.
            S_DATA: begin
                if (r_cnt == c_full_bit) begin
                    w_cnt_clear  = 1'b1;
                    w_sample_bit = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (r_cnt == c_full_bit) begin
                    w_cnt_clear = 1'b1;
                    if (w_rxs) begin
                        w_next_state = S_WRITE;
                    end else begin
                        w_next_state = S_WAIT_HIGH;
                        w_stop_err   = 1'b1;
                    end
                end
            end

            // A held-low line must return high before a new start is accepted.
            S_WAIT_HIGH: begin
                if (w_rxs) begin
                    w_next_state = S_IDLE;
                end
            end

            S_WRITE: begin
                w_write      = 1'b1;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Bit timing counter (saturating) and data shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 8'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            if (w_cnt_clear) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_start_det) begin
                r_bit_idx <= 3'd0;
            end else if (w_sample_bit) begin
                r_shift[r_bit_idx] <= w_rxs;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional mid-frame idle timeout
    // ------------------------------------------------------------------------
`ifdef CC_RX_TIMEOUT_EN
    localparam int                  c_idle_w       = $clog2(TIMEOUT + 1);
    localparam logic [c_idle_w-1:0] c_timeout_last = c_idle_w'(TIMEOUT - 1);

    logic [c_idle_w-1:0] r_idle_cnt;

    // Fires on the idle clock that would bring the count to TIMEOUT.
    assign w_timeout = (r_state == S_IDLE) && !w_start_det &&
                       (r_bytes_rcvd != 13'd0) && (r_idle_cnt == c_timeout_last);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= '0;
        end else if (w_start_det || w_timeout || (r_bytes_rcvd == 13'd0)) begin
            r_idle_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    // No idle counter: a partial frame waits indefinitely. TIMEOUT is a
    // positive count, so this term is constant zero.
    assign w_timeout = (TIMEOUT < 0);
`endif

    // ------------------------------------------------------------------------
    // Buffer write interface and frame bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wraddress  <= 12'd0;
            r_wrdata     <= 8'd0;
            r_wren       <= 1'b0;
            r_frame_rdy  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_bytes_rcvd <= 13'd0;
        end else begin
            r_wren      <= (w_next_state == S_WRITE);
            r_frame_rdy <= 1'b0;

            // Address and data are captured as WRITE is entered so they are
            // stable for the whole strobe.
            if (w_next_state == S_WRITE) begin
                r_wraddress <= r_bytes_rcvd[11:0];
                r_wrdata    <= r_shift;
            end

            if (w_write) begin
                if (r_bytes_rcvd == c_last_byte) begin
                    r_bytes_rcvd <= 13'd0;
                    r_frame_rdy  <= 1'b1;
                    r_frame_err  <= 1'b0;
                end else begin
                    r_bytes_rcvd <= r_bytes_rcvd + 13'd1;
                end
            end else if (w_timeout) begin
                r_bytes_rcvd <= 13'd0;
                r_frame_err  <= 1'b1;
            end

            if (w_stop_err) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign wraddress  = r_wraddress;
    assign wrdata     = r_wrdata;
    assign wren       = r_wren;
    assign frame_rdy  = r_frame_rdy;
    assign frame_err  = r_frame_err;
    assign bytes_rcvd = r_bytes_rcvd;

endmodule

`default_nettype wire

// File: tb/tb_cc_receive.sv
// ============================================================================
//  Module      : tb_cc_receive
//  Description : Directed self-checking bench for cc_receive. Uses a
//                16-byte frame so a complete frame fits a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cc_receive;

    localparam int SUBFRAME = 16;

    logic        clock;
    logic        reset;
    logic        rx;
    logic [11:0] wraddress;
    logic [7:0]  wrdata;
    logic        wren;
    logic        frame_rdy;
    logic        frame_err;
    logic [12:0] bytes_rcvd;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          q_cyc[$];
    logic [11:0] q_addr[$];
    logic [7:0]  q_data[$];
    int          q_rdy[$];

    cc_receive #(
        .SUBFRAME    (SUBFRAME),
        .BIT_PERIOD  (50),
        .SYNC_STAGES (2),
        .TIMEOUT     (4096)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .wraddress  (wraddress),
        .wrdata     (wrdata),
        .wren       (wren),
        .frame_rdy  (frame_rdy),
        .frame_err  (frame_err),
        .bytes_rcvd (bytes_rcvd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output monitor, sampled on the falling edge.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (wren) begin
            q_cyc.push_back(cyc);
            q_addr.push_back(wraddress);
            q_data.push_back(wrdata);
        end
        if (frame_rdy) q_rdy.push_back(cyc);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clock);
    endtask

    // Start bit plus data bits; jitter alternates 51/50-clock bits.
    task automatic send_bits(input logic [7:0] d, input int nbits, input bit jitter);
        hold(1'b0, jitter ? 51 : 50);
        for (int i = 0; i < nbits; i++) hold(d[i], (jitter && (i % 2 == 1)) ? 51 : 50);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_lvl, input bit jitter);
        send_bits(d, 8, jitter);
        hold(stop_lvl, 50);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wraddress"},  32'(wraddress),  32'h0);
        check({tag, "_wrdata"},     32'(wrdata),     32'h0);
        check({tag, "_wren"},       32'(wren),       32'h0);
        check({tag, "_frame_rdy"},  32'(frame_rdy),  32'h0);
        check({tag, "_frame_err"},  32'(frame_err),  32'h0);
        check({tag, "_bytes_rcvd"}, 32'(bytes_rcvd), 32'h0);
    endtask

    initial begin
        int t_start;
        int n0;
        int base;
        int lat;

        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (5) @(posedge clock);

        // ---- single byte 0xA5 with 50/51 jitter ----
        n0      = q_cyc.size();
        t_start = cyc;
        send_byte(8'hA5, 1'b1, 1'b1);
        hold(1'b1, 50);
        @(negedge clock);
        check("a5_wren_count", 32'(q_cyc.size() - n0), 32'd1);
        if (q_cyc.size() > n0) begin
            lat = q_cyc[n0] - t_start;
            check("a5_wrdata",    32'(q_data[n0]), 32'hA5);
            check("a5_wraddress", 32'(q_addr[n0]), 32'h0);
            check("a5_latency_in_window", 32'(lat >= 478 && lat <= 480), 32'd1);
        end
        check("a5_bytes_rcvd", 32'(bytes_rcvd), 32'd1);
        check("a5_frame_err",  32'(frame_err),  32'd0);
        @(posedge clock);

        // ---- 20-clock glitch ----
        n0 = q_cyc.size();
        hold(1'b0, 20);
        hold(1'b1, 100);
        @(negedge clock);
        check("glitch_no_wren",    32'(q_cyc.size() - n0), 32'd0);
        check("glitch_bytes_rcvd", 32'(bytes_rcvd), 32'd1);
        check("glitch_frame_err",  32'(frame_err),  32'd0);
        check("glitch_state_idle", 32'(dut.r_state), 32'd0);
        @(posedge clock);

        // ---- stop bit low, line held low, then byte 0x11 ----
        do_reset();
        n0 = q_cyc.size();
        send_byte(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 300);
        hold(1'b1, 60);
        @(negedge clock);
        check("badstop_no_wren",   32'(q_cyc.size() - n0), 32'd0);
        check("badstop_frame_err", 32'(frame_err),  32'd1);
        check("badstop_bytes",     32'(bytes_rcvd), 32'd0);
        @(posedge clock);
        n0 = q_cyc.size();
        send_byte(8'h11, 1'b1, 1'b0);
        hold(1'b1, 20);
        @(negedge clock);
        check("after_err_wren_count", 32'(q_cyc.size() - n0), 32'd1);
        if (q_cyc.size() > n0) begin
            check("after_err_wrdata",    32'(q_data[n0]), 32'h11);
            check("after_err_wraddress", 32'(q_addr[n0]), 32'h0);
        end
        check("after_err_frame_err_sticky", 32'(frame_err), 32'd1);
        @(posedge clock);

        // ---- full frame, back-to-back, frame_err set beforehand ----
        do_reset();
        send_byte(8'h3C, 1'b0, 1'b0);
        hold(1'b1, 60);
        @(negedge clock);
        check("preframe_frame_err", 32'(frame_err), 32'd1);
        @(posedge clock);
        base = q_cyc.size();
        n0   = q_rdy.size();
        for (int i = 0; i < SUBFRAME; i++) send_byte(8'(i), 1'b1, 1'b0);
        hold(1'b1, 20);
        @(negedge clock);
        check("frame_wren_count", 32'(q_cyc.size() - base), 32'(SUBFRAME));
        if (q_cyc.size() - base == SUBFRAME) begin
            for (int i = 0; i < SUBFRAME; i++) begin
                check($sformatf("frame_addr_%0d", i), 32'(q_addr[base+i]), 32'(i));
                check($sformatf("frame_data_%0d", i), 32'(q_data[base+i]), 32'(i));
            end
        end
        check("frame_rdy_count", 32'(q_rdy.size() - n0), 32'd1);
        if ((q_rdy.size() - n0 == 1) && (q_cyc.size() > 0))
            check("frame_rdy_after_last_wren", 32'(q_rdy[n0] - q_cyc[q_cyc.size()-1]), 32'd1);
        check("frame_bytes_rcvd_zero", 32'(bytes_rcvd), 32'd0);
        check("frame_err_cleared",     32'(frame_err),  32'd0);
        @(posedge clock);

        // ---- reset during bit 4 of byte 10 ----
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1), 1'b1, 1'b0);
        @(negedge clock);
        check("pre_reset_bytes", 32'(bytes_rcvd), 32'd10);
        @(posedge clock);
        send_bits(8'hFF, 4, 1'b0);
        hold(1'b1, 25);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("midbyte_reset");
        rx = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        hold(1'b1, 10);
        n0 = q_cyc.size();
        send_byte(8'h5A, 1'b1, 1'b0);
        hold(1'b1, 20);
        @(negedge clock);
        check("post_reset_wren_count", 32'(q_cyc.size() - n0), 32'd1);
        if (q_cyc.size() > n0) begin
            check("post_reset_wraddress", 32'(q_addr[n0]), 32'h0);
            check("post_reset_wrdata",    32'(q_data[n0]), 32'h5A);
        end
        @(posedge clock);

        // ---- partial frame of 10 bytes, then long idle ----
        for (int i = 0; i < 9; i++) send_byte(8'hC0 + 8'(i), 1'b1, 1'b0);
        @(negedge clock);
        check("partial_bytes", 32'(bytes_rcvd), 32'd10);
        @(posedge clock);
        n0 = q_rdy.size();
        hold(1'b1, 4200);
        @(negedge clock);
`ifdef CC_RX_TIMEOUT_EN
        check("timeout_bytes_cleared", 32'(bytes_rcvd), 32'd0);
        check("timeout_frame_err",     32'(frame_err),  32'd1);
`else
        check("no_timeout_bytes_kept", 32'(bytes_rcvd), 32'd10);
        check("no_timeout_frame_err",  32'(frame_err),  32'd0);
`endif
        check("idle_no_frame_rdy", 32'(q_rdy.size() - n0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
